// File: rtl/interp_mac_datapath.sv
// Polyphase interpolator datapath: sample and coefficient RAMs feeding one signed
// multiplier and accumulator; emits one rounded, saturated sample per branch.
module interp_mac_datapath #(
    parameter int DataWidth  = 16,
    parameter int CoeffWidth = 16,
    parameter int AccWidth   = 36,
    parameter int OutWidth   = 16,
    parameter int ShiftR     = 15
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic                  DataNd_i,
    input  logic [DataWidth-1:0]  Data_i,
    input  logic [3:0]            DataAddrWr_i,
    input  logic [3:0]            DataAddr_i,
    input  logic [3:0]            CoeffAddr_i,
    input  logic                  StartAcc_i,
    input  logic                  DataValid_i,
    input  logic                  CoeffWe_i,
    input  logic [3:0]            CoeffWrAddr_i,
    input  logic [CoeffWidth-1:0] CoeffWrData_i,
    output logic [OutWidth-1:0]   Data_o,
    output logic                  Valid_o
);

    localparam int ProdWidth  = DataWidth + CoeffWidth;
    localparam int RoundShift = (ShiftR > 0) ? ShiftR - 1 : 0;
    localparam logic signed [AccWidth:0] RoundConst =
        (ShiftR > 0) ? ({{AccWidth{1'b0}}, 1'b1} << RoundShift) : '0;
    localparam logic signed [AccWidth:0] OutMax =
        {{(AccWidth + 2 - OutWidth){1'b0}}, {(OutWidth - 1){1'b1}}};
    localparam logic signed [AccWidth:0] OutMin =
        {{(AccWidth + 2 - OutWidth){1'b1}}, {(OutWidth - 1){1'b0}}};

    logic [DataWidth-1:0]  sample_mem [16];
    logic [CoeffWidth-1:0] coeff_mem  [16];

    logic signed [DataWidth-1:0]  d_q;
    logic signed [CoeffWidth-1:0] c_q;
    logic signed [ProdWidth-1:0]  p_q, p_d;
    logic signed [AccWidth-1:0]   acc_q, acc_d;
    logic [OutWidth-1:0]          data_q, data_d;
    logic                         valid_q, valid_d;

    logic signed [ProdWidth-1:0] d_ext, c_ext;
    logic signed [AccWidth-1:0]  p_ext;
    logic signed [AccWidth:0]    sum_r, shifted;

    // NOTE: the RAM arrays carry no reset so they map onto memory primitives;
    // their contents deliberately survive Rst_i.
    always_ff @(posedge Clk_i) begin
        if (DataNd_i) begin
            sample_mem[DataAddrWr_i] <= Data_i;
        end
        if (CoeffWe_i) begin
            coeff_mem[CoeffWrAddr_i] <= CoeffWrData_i;
        end
    end

    assign d_ext = $signed({{CoeffWidth{d_q[DataWidth-1]}}, d_q});
    assign c_ext = $signed({{DataWidth{c_q[CoeffWidth-1]}}, c_q});
    assign p_d   = d_ext * c_ext;
    assign p_ext = $signed({{(AccWidth - ProdWidth){p_q[ProdWidth-1]}}, p_q});

    // Rounding uses acc before this edge's reload, so back-to-back branches are safe.
    assign sum_r   = $signed({acc_q[AccWidth-1], acc_q}) + RoundConst;
    assign shifted = sum_r >>> ShiftR;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        acc_d   = StartAcc_i ? p_ext : acc_q + p_ext;
        valid_d = DataValid_i;
        data_d  = data_q;
        if (DataValid_i) begin
            if (shifted > OutMax) begin
                data_d = {1'b0, {(OutWidth - 1){1'b1}}};
            end else if (shifted < OutMin) begin
                data_d = {1'b1, {(OutWidth - 1){1'b0}}};
            end else begin
                data_d = shifted[OutWidth-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the previous stage's pre-edge value.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            d_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            d_q     <= sample_mem[DataAddr_i];
            c_q     <= coeff_mem[CoeffAddr_i];
            p_q     <= p_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign Data_o  = data_q;
    assign Valid_o = valid_q;

endmodule

// File: doc/interp_mac_datapath.md
# interp_mac_datapath

Single-multiplier datapath of the polyphase interpolator. It sits directly downstream of the interpolator control block and consumes that block's data write address, read addresses, StartAcc and DataValid strobes. It holds the input-sample RAM and the coefficient RAM, and computes one signed multiply-accumulate per clock. It emits one rounded, saturated output sample per completed polyphase branch, so InterpolationK outputs per input sample.

## Interface
- DataWidth, 16, signed input sample width
- CoeffWidth, 16, signed coefficient width
- AccWidth, 36, accumulator width; must be ≥ DataWidth+CoeffWidth+4
- OutWidth, 16, signed output width
- ShiftR, 15, accumulator right shift before rounding (0 allowed)
- Clk_i  in  1  clock
- Rst_i  in  1  reset, asynchronous, active-high
- DataNd_i  in  1  new input sample strobe
- Data_i  in  DataWidth  input sample, valid with DataNd_i
- DataAddrWr_i  in  4  sample RAM write address (from control block)
- DataAddr_i  in  4  sample RAM read address (from control block)
- CoeffAddr_i  in  4  coefficient RAM read address (from control block)
- StartAcc_i  in  1  first product of a branch is at the multiplier output
- DataValid_i  in  1  accumulator holds a completed branch sum
- CoeffWe_i  in  1  coefficient write enable
- CoeffWrAddr_i  in  4  coefficient write address
- CoeffWrData_i  in  CoeffWidth  coefficient write data
- Data_o  out  OutWidth  interpolated output sample
- Valid_o  out  1  one-cycle strobe, Data_o valid

## Operation
- Sample RAM: 16 x DataWidth.
  - Written at Data_i/DataAddrWr_i on every edge with DataNd_i=1.
  - Synchronous registered read at DataAddr_i.
  - A read of the address written on the previous edge returns the new sample.
- Coefficient RAM: 16 x CoeffWidth.
  - Written when CoeffWe_i=1; synchronous registered read at CoeffAddr_i.
  - Simultaneous write and read of the same address returns the old value.
  - Coefficients are loaded only while no branch is in progress.
- Neither RAM is reset; contents survive Rst_i.
- Pipeline:
  - stage 1: dReg, cReg (RAM read registers).
  - stage 2: pReg = dReg*cReg, signed, full DataWidth+CoeffWidth width.
  - stage 3: acc.
- Accumulate rule, every edge:
  - StartAcc_i=1: acc <= sign-extended pReg.
  - Otherwise: acc <= acc + sign-extended pReg, two's-complement wrap at AccWidth.
- The accumulator runs continuously, including while the control block is idle. Content outside a branch is don't-care; the next StartAcc_i reloads it.
- Output, on each edge with DataValid_i=1:
  - r = (acc + (ShiftR>0 ? 2^(ShiftR-1) : 0)) >>> ShiftR, arithmetic shift, computed at AccWidth+1 bits.
  - Data_o <= r saturated to [-2^(OutWidth-1), 2^(OutWidth-1)-1].
  - Valid_o <= 1.
- Otherwise Valid_o <= 0 and Data_o holds.
- DataValid_i and StartAcc_i coincide on back-to-back branches. Output capture uses acc before that edge's reload; both actions happen on the same edge.

## Timing
- Reset: dReg, cReg, pReg, acc, Data_o = 0; Valid_o = 0. Asynchronous clear, takes effect immediately even mid-branch.
- After reset release, no Valid_o until a DataValid_i arrives. The partial branch is lost.
- Address at cycle t → dReg/cReg at t+1 → pReg at t+2 → included in acc at edge t+3.
- StartAcc_i arrives 2 cycles after the first address of its branch, aligned with pReg of that address.
- DataValid_i arrives at the StartAcc_i time of the following branch, or the equivalent cycle if idle. acc then holds the full branch sum.
- Valid_o asserts 1 cycle after DataValid_i, for exactly 1 cycle per DataValid_i.
- Branch length = FilterLength/InterpolationK products. No throughput limit beyond one product per cycle.

## Test plan
- Impulse:
  - Setup: ShiftR=0, K=2, FL=16, coeff[n]=n+1. Input x=1 then seven zeros, driven through the real control block.
  - Required: first outputs 1, 2 (branch 0 then branch 1), next 3, 4, …, ending at 15, 16. Each output arrives with a one-cycle Valid_o.
- DC gain:
  - Setup: ShiftR=15, coeff[n]=4096, constant x=8192.
  - Required: after 8 inputs every output = 8192 (8·4096·8192 >> 15).
- Rounding/saturation:
  - ShiftR=1, acc=3 → Data_o=2.
  - acc=-3 → Data_o=-1.
  - acc=2^20 → Data_o=32767.
  - acc=-2^20 → Data_o=-32768.
- Back-to-back:
  - Stimulus: DataNd_i held every 16 cycles with no idle gap.
  - Required: exactly 2 Valid_o per input, each spaced 8 cycles. No product leaks across branches (check against a reference model).
- Reset mid-branch:
  - Stimulus: assert Rst_i for 1 cycle in the middle of a branch.
  - Required: Data_o=0 and Valid_o=0 immediately. Coefficient RAM is unchanged. The next full input sequence yields correct outputs.
- Coefficient write collision:
  - Stimulus: CoeffWe_i to address 5 on the same edge as a read of address 5 while idle.
  - Required: the read returns the old value; the next read returns the new value.
